bt_report_tx: RTL and testbench
===============================

// Module: bt_report_tx
// PURPOSE
//   UART transmitter returning status reports to the Bluetooth host over BT_Tx (8N1, LSB first, idle high).
//   - On request, sends a Pattern acknowledgement or a frame-configuration report.
//   - Report characters use the same ASCII encoding the BT command receiver decodes.
//   - Sits beside the BT command block, on the host-bound side of the same serial link.
// PARAMETERS
//   CLKS_PER_BIT  1000  CLOCK_10 cycles per UART bit (10 MHz / 1000 = 10 kbaud); legal range 2..65535
// PORTS
//   CLOCK_10      in   1   system clock, 10 MHz; single clock domain
//   reset         in   1   asynchronous, active-high reset
//   send_pattern  in   1   1-cycle request: send Pattern acknowledgement
//   send_frame    in   1   1-cycle request: send frame report
//   Pattern       in   3   current pattern code, 0..7
//   frameNum      in   3   current frame count, 0..7
//   frameRate     in   32  eight 4-bit digits; [3:0] is the first digit sent
//   BT_Tx         out  1   serial line to BT module
//   busy          out  1   high while a message is in flight
//   done          out  1   1-cycle pulse when the message completes
// BEHAVIOUR
//   Reset:
//   - Reset asserts asynchronously: BT_Tx=1, busy=0, done=0, FSM=IDLE.
//   - Reset asserted mid-message aborts the message immediately; nothing resumes after release.
//   Messages (bytes in send order):
//   - Pattern ack, 4 bytes: 'P'(0x50), 0x30+Pattern, CR(0x0D), LF(0x0A).
//   - Frame report, 12 bytes: 'f'(0x66), 0x30+frameNum, digits d0..d7, CR, LF.
//     d_i = frameRate[4i+3:4i]. Digit byte = 0x30+d_i when d_i<=9, else '?'(0x3F).
//   Request acceptance:
//   - Requests are sampled only in IDLE; requests arriving while busy=1 are dropped (no queue).
//   - send_frame and send_pattern high in the same cycle: the frame report is sent, send_pattern is dropped.
//   - On acceptance, Pattern, frameNum and frameRate are snapshotted; later input changes do not affect the message.
//   Timing:
//   - Request seen at edge k: busy=1 and BT_Tx=0 (start bit) from edge k+1.
//   - Each bit lasts exactly CLKS_PER_BIT cycles.
//   - Byte = start bit (0), 8 data bits LSB first, stop bit (1). Bytes are back-to-back, with no idle gap between them.
//   - Message of N bytes: busy lasts exactly 10*N*CLKS_PER_BIT cycles.
//   - At the cycle after the last stop bit ends: done=1 for one cycle, busy=0, BT_Tx=1. A new request is accepted in that same cycle.
//   FSM states:
//   - IDLE  -> LOAD on an accepted request.
//   - LOAD  : select the byte at byte_idx, then -> START. LOAD is merged into the IDLE/STOP exits, so it adds 0 cycles.
//   - START -> DATA after CLKS_PER_BIT cycles.
//   - DATA  -> STOP after 8 bits.
//   - STOP  -> LOAD when byte_idx < N-1, otherwise -> IDLE and assert done.
//   Widths:
//   - Bit timer is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
//   - Bit counter is 3 bits; byte_idx is 4 bits (max 11).
//   - Digit byte = {4'h3, d} when d<=9. No BCD carry or range correction beyond the '?' substitution.
// STRUCTURE
//   Package bt_pkg:
//   - ASCII constants: CH_P, CH_f, CH_0, CH_Q, CH_CR, CH_LF.
//   - Message lengths: LEN_PAT=4, LEN_FRM=12.
//   - tx_state_t enum: IDLE, START, DATA, STOP.
//   Sub-module uart_tx_byte:
//   - Ports: start/ready handshake, 8-bit data in, CLKS_PER_BIT parameter.
//   - Owns the bit timer, bit counter and shift register.
//   Top level:
//   - Owns request arbitration, the snapshot registers, the byte_idx sequencer and the byte-select mux.
// TESTING (CLKS_PER_BIT=4 unless noted)
//   1. Pattern=3, pulse send_pattern -> bytes 50 33 0D 0A decoded; busy high exactly 160 cycles; then one done pulse.
//   2. frameNum=5, frameRate=32'h0000_4321, pulse send_frame
//      -> bytes 66 35 31 32 33 34 30 30 30 30 0D 0A; busy 480 cycles.
//   3. frameRate=32'h0000_00A0, frame report -> digit bytes 30 3F 30 30 30 30 30 30; frameRate changed mid-message -> output unchanged.
//   4. send_frame and send_pattern in the same cycle -> only the 12-byte frame report is sent.
//      send_pattern during busy -> dropped; BT_Tx idles high after done.
//   5. Assert reset during byte 2 of a frame report -> BT_Tx=1 and busy=0 in the same cycle (async).
//      After release, line stays idle until a new request.
//   6. CLKS_PER_BIT=1000 -> start-bit width measured at 1000 cycles (100 us @ 10 MHz);
//      done pulsed back-to-back with an immediate new request -> second message starts on the next edge, with no idle gap.

Source files
------------

// File: rtl/bt_pkg.sv
// bt_pkg: ASCII constants, message lengths and UART state type shared by the BT report transmitter.
package bt_pkg;
  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_f  = 8'h66;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_Q  = 8'h3F;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [3:0] LEN_PAT = 4'd4;
  localparam logic [3:0] LEN_FRM = 4'd12;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  function automatic logic [7:0] digit_ch(input logic [3:0] d);
    return d <= 4'd9 ? {4'h3, d} : CH_Q;
  endfunction
endpackage

// File: rtl/bt_report_tx_uart.sv
// uart_tx_byte: 8N1 byte serialiser; a new byte may be loaded in the last stop-bit cycle for gapless output.
module uart_tx_byte
  import bt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  tx_state_t state, state_n;
  logic [TW-1:0] timer;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic tick, load;
  assign tick  = timer == TW'(CLKS_PER_BIT - 1);
  assign ready = state == IDLE || (state == STOP && tick);
  assign load  = ready && start;
  assign tx    = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
  always_comb begin
    state_n = state;
    if (load) state_n = START;
    else if (tick)
      state_n = state == START ? DATA :
                state == DATA  ? (bit_cnt == 3'd7 ? STOP : DATA) :
                state == STOP  ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '1;
    end else begin
      timer <= (state == IDLE || tick) ? '0 : timer + 1'b1;
      if (load) begin
        shreg   <= data;
        bit_cnt <= '0;
      end else if (state == DATA && tick) begin
        shreg   <= {1'b1, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
endmodule

// File: rtl/bt_report_tx.sv
// bt_report_tx: sends Pattern acks and frame reports to the BT host as back-to-back 8N1 bytes.
module bt_report_tx
  import bt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1000
) (
  input  logic        CLOCK_10,
  input  logic        reset,
  input  logic        send_pattern,
  input  logic        send_frame,
  input  logic [2:0]  Pattern,
  input  logic [2:0]  frameNum,
  input  logic [31:0] frameRate,
  output logic        BT_Tx,
  output logic        busy,
  output logic        done
);
  logic active, is_frm, accept, ready, start, more;
  logic [3:0] byte_idx, nidx, last, d;
  logic [2:0] pat_q, fnum_q;
  logic [31:0] rate_q;
  logic [7:0] nxt, data;
  assign accept = !active && (send_frame || send_pattern);
  assign last   = (is_frm ? LEN_FRM : LEN_PAT) - 4'd1;
  assign more   = byte_idx != last;
  assign start  = accept || (active && ready && more);
  assign busy   = active;
  // The header byte is constant, so the first byte can start before the snapshot lands.
  always_comb begin
    nidx = byte_idx + 4'd1;
    d    = 4'(rate_q >> {nidx - 4'd2, 2'b00});
    nxt  = is_frm ? (nidx == 4'd1  ? CH_0 + {5'b0, fnum_q} :
                     nidx == 4'd10 ? CH_CR :
                     nidx == 4'd11 ? CH_LF : digit_ch(d)) :
                    (nidx == 4'd1  ? CH_0 + {5'b0, pat_q} :
                     nidx == 4'd2  ? CH_CR : CH_LF);
    data = accept ? (send_frame ? CH_f : CH_P) : nxt;
  end
  always_ff @(posedge CLOCK_10 or posedge reset)
    if (reset) begin
      active   <= 1'b0;
      is_frm   <= 1'b0;
      byte_idx <= '0;
      pat_q    <= '0;
      fnum_q   <= '0;
      rate_q   <= '0;
      done     <= 1'b0;
    end else begin
      done <= active && ready && !more;
      if (accept) begin
        active   <= 1'b1;
        is_frm   <= send_frame;
        byte_idx <= '0;
        pat_q    <= Pattern;
        fnum_q   <= frameNum;
        rate_q   <= frameRate;
      end else if (active && ready) begin
        if (more) byte_idx <= nidx;
        else active <= 1'b0;
      end
    end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(CLOCK_10),
    .rst(reset),
    .start(start),
    .data(data),
    .ready(ready),
    .tx(BT_Tx)
  );
endmodule

// File: tb/tb_bt_report_tx.sv
// tb_bt_report_tx: table-driven message checks at CLKS_PER_BIT=4 plus reset and full-rate timing sequences.
module tb_bt_report_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sp = 1'b0, sf = 1'b0, sp_k = 1'b0;
  logic [2:0] pat = '0, fnum = '0;
  logic [31:0] rate = '0;
  logic tx, busy, done, tx_k, busy_k, done_k;
  int tests = 0, fails = 0;
  typedef struct {
    logic sf, sp;
    logic [2:0] pat, fnum;
    logic [31:0] rate;
    int n;
    logic [95:0] exp;
    logic mut, chain;
  } vec_t;
  vec_t v[6];
  logic s[600];
  always #50 clk = ~clk;
  bt_report_tx #(.CLKS_PER_BIT(4)) dut (
    .CLOCK_10(clk), .reset(reset), .send_pattern(sp), .send_frame(sf),
    .Pattern(pat), .frameNum(fnum), .frameRate(rate),
    .BT_Tx(tx), .busy(busy), .done(done)
  );
  bt_report_tx #(.CLKS_PER_BIT(1000)) dut_k (
    .CLOCK_10(clk), .reset(reset), .send_pattern(sp_k), .send_frame(1'b0),
    .Pattern(pat), .frameNum(fnum), .frameRate(rate),
    .BT_Tx(tx_k), .busy(busy_k), .done(done_k)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  task automatic setv(input int i, input logic f, input logic p, input logic [2:0] pa,
                      input logic [2:0] fn, input logic [31:0] r, input int n,
                      input logic [95:0] e, input logic m, input logic c);
    v[i].sf = f; v[i].sp = p; v[i].pat = pa; v[i].fnum = fn; v[i].rate = r;
    v[i].n = n; v[i].exp = e; v[i].mut = m; v[i].chain = c;
  endtask
  task automatic drive(input int i);
    sf = v[i].sf; sp = v[i].sp; pat = v[i].pat; fnum = v[i].fnum; rate = v[i].rate;
  endtask
  initial begin
    int cnt, lo, hi;
    logic chained;
    logic [9:0] fr;
    logic [7:0] eb;
    setv(0, 1'b0, 1'b1, 3'd3, 3'd0, 32'h0, 4, {32'h50330D0A, 64'h0}, 1'b0, 1'b0);
    setv(1, 1'b1, 1'b0, 3'd0, 3'd5, 32'h0000_4321, 12, 96'h66_35_31_32_33_34_30_30_30_30_0D_0A, 1'b0, 1'b0);
    setv(2, 1'b1, 1'b0, 3'd1, 3'd2, 32'h0000_00A0, 12, 96'h66_32_30_3F_30_30_30_30_30_30_0D_0A, 1'b1, 1'b0);
    setv(3, 1'b1, 1'b1, 3'd6, 3'd7, 32'h9876_5432, 12, 96'h66_37_32_33_34_35_36_37_38_39_0D_0A, 1'b0, 1'b1);
    setv(4, 1'b0, 1'b1, 3'd7, 3'd0, 32'h0, 4, {32'h50370D0A, 64'h0}, 1'b0, 1'b1);
    setv(5, 1'b1, 1'b0, 3'd0, 3'd0, 32'hFEDC_BA98, 12, 96'h66_30_38_39_3F_3F_3F_3F_3F_3F_0D_0A, 1'b0, 1'b0);
    #1;
    chk("reset_state", {29'b0, tx, busy, done}, 32'b100);
    chk("reset_state_k", {29'b0, tx_k, busy_k, done_k}, 32'b100);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chained = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!chained) begin
        drive(i);
        @(negedge clk);
        sf = 1'b0; sp = 1'b0;
      end
      cnt = 0;
      while (busy && cnt < 600) begin
        s[cnt] = tx;
        if (v[i].mut) begin
          if (cnt == 50) begin rate = 32'hFFFF_FFFF; fnum = 3'd7; pat = 3'd5; end
          if (cnt == 60) sp = 1'b1;
          if (cnt == 61) sp = 1'b0;
        end
        cnt++;
        @(negedge clk);
      end
      chk($sformatf("v%0d_busy_len", i), cnt, v[i].n * 40);
      for (int b = 0; b < v[i].n; b++) begin
        for (int j = 0; j < 10; j++) fr[j] = s[b*40 + j*4 + 2];
        eb = v[i].exp[95 - 8*b -: 8];
        chk($sformatf("v%0d_byte%0d", i, b), {22'b0, fr}, {22'b0, 1'b1, eb, 1'b0});
      end
      chk($sformatf("v%0d_done_pulse", i), {29'b0, done, tx, busy}, 32'b110);
      if (v[i].chain) drive(i + 1);
      @(negedge clk);
      sf = 1'b0; sp = 1'b0;
      chk($sformatf("v%0d_done_clear", i), {31'b0, done}, 32'b0);
      if (v[i].chain) chk($sformatf("v%0d_b2b_start", i), {30'b0, busy, tx}, 32'b10);
      else chk($sformatf("v%0d_idle_after", i), {30'b0, busy, tx}, 32'b01);
      chained = v[i].chain;
    end
    hi = 0;
    repeat (20) begin
      if (tx !== 1'b1 || busy !== 1'b0) hi++;
      @(negedge clk);
    end
    chk("idle_hold", hi, 0);
    fnum = 3'd1; rate = 32'h0000_4321; sf = 1'b1;
    @(negedge clk);
    sf = 1'b0;
    repeat (81) @(negedge clk);
    chk("pre_reset_start_bit", {30'b0, busy, tx}, 32'b10);
    #10 reset = 1'b1;
    #1 chk("async_reset", {29'b0, busy, tx, done}, 32'b010);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) hi++;
    end
    chk("idle_after_reset", hi, 0);
    sp_k = 1'b1;
    @(negedge clk);
    sp_k = 1'b0;
    chk("k_start", {30'b0, busy_k, tx_k}, 32'b10);
    lo = 0;
    while (tx_k === 1'b0 && lo < 8000) begin lo++; @(negedge clk); end
    chk("k_low_run", lo, 5000);
    hi = 0;
    while (tx_k === 1'b1 && hi < 3000) begin hi++; @(negedge clk); end
    chk("k_bit_width", hi, 1000);
    #10 reset = 1'b1;
    #1 chk("k_async_reset", {30'b0, busy_k, tx_k}, 32'b01);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
